// File: rtl/gf180mcu_fd_sc_mcu7t5v0__prbs7_xnor_chk.sv
// Serial PRBS7 checker (x^7 + x^6 + 1, XNOR feedback): self-seeds in HUNT,
// free-runs in LOCK, and flags and counts received bit errors while locked.
module gf180mcu_fd_sc_mcu7t5v0__prbs7_xnor_chk #(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned MISS_LIM = 4,
  parameter int unsigned CW       = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          D,
  input  logic          CLR,
  output logic          LOCK,
  output logic          ERR,
  output logic [CW-1:0] ERRCNT,
  inout  logic          VDD,
  inout  logic          VSS
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [7:0] LOCK_V = LOCK_CNT[7:0];
  localparam logic [3:0] MISS_V = MISS_LIM[3:0];

  state_t        state_q, state_d;
  logic [6:0]    s_q, s_d;
  logic [2:0]    fill_q, fill_d;
  logic [7:0]    match_q, match_d;
  logic [3:0]    miss_q, miss_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p;
  logic          mism;
  logic          unused_pwr;

  assign unused_pwr = VDD ^ VSS;

  assign p    = ~(s_q[6] ^ s_q[5]);
  assign mism = D ^ p;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HUNT;
      s_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (EN) begin
      unique case (state_q)
        HUNT: begin
          s_d = {s_q[5:0], D};
          if (fill_q != 3'd7) fill_d = fill_q + 3'd1;
          // All-ones is the XNOR lockup state; never let it build credit.
          if (s_q == '1)
            match_d = '0;
          else if (fill_q == 3'd7)
            match_d = mism ? '0 : match_q + 8'd1;
          if (match_d == LOCK_V) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end
        LOCKED: begin
          s_d = {s_q[5:0], p};
          if (mism) begin
            err_d  = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            miss_d = miss_q + 4'd1;
            if (miss_d == MISS_V) begin
              state_d = HUNT;
              match_d = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: ;
      endcase
    end
    if (CLR) cnt_d = '0;
  end

  assign LOCK   = (state_q == LOCKED);
  assign ERR    = err_q;
  assign ERRCNT = cnt_q;

endmodule
